smooth_main: RTL and testbench
==============================

# smooth_main

Moving-average front end for the hit detection path. Takes raw ADC samples, averages them over a configurable power-of-two window, subtracts a programmable baseline with floor-at-zero, and delivers the result as the `sm_data`/`sm_vld` stream that the hit FSM compares against its threshold. Reports fill state and a running output count to the register bank.

## Interface
- `SM_DEPTH`, 16: ring buffer depth; maximum window length.
- `SM_LEN_MAX`, 4: maximum window exponent, log2(`SM_DEPTH`).
- `clk_sys`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `adc_data`  in  16  raw unsigned ADC sample.
- `adc_vld`  in  1  sample strobe, one cycle per sample; back-to-back allowed.
- `cfg_sm_len`  in  3  window exponent k; window L = 2^k. Values 5–7 clamp to 4.
- `cfg_base`  in  16  baseline subtracted from the average.
- `sm_data`  out  16  baseline-corrected average.
- `sm_vld`  out  1  one-cycle strobe qualifying `sm_data`.
- `stu_sm_ready`  out  1  window full; outputs are being produced.
- `stu_sm_cnt`  out  16  count of `sm_vld` pulses, wraps at 16'hFFFF→0.

## Operation
- Effective exponent: ke = min(`cfg_sm_len`, 4); L = 1 << ke.
- Ring buffer: 16 × 16-bit, write pointer `wr_ptr` (4-bit, wraps 15→0). Each accepted sample is written at `wr_ptr`, then `wr_ptr` increments.
- Running sum, 20 bits unsigned: sum ← sum + `adc_data` − buf[(`wr_ptr` − L) mod 16]. The sum never overflows: 16 × 65535 < 2^20.
- Fill counter `fill` (5-bit): increments per sample, saturates at L. `stu_sm_ready` = (`fill` == L).
- Output is produced only for samples accepted while `fill` reaches or already equals L. No output is produced during fill.
- avg = sum >> ke, truncated. `sm_data` = (avg > `cfg_base`) ? avg − `cfg_base` : 0.
- Window change: ke is registered every cycle. When the new ke differs from the registered value, flush:
  - buffer entries, sum, `fill` and `wr_ptr` all go to 0;
  - any sample present on `adc_vld` in the flush cycle is dropped.
- `cfg_base` is not flushed. It takes effect on the next output.
- Reset values: `sm_data` 0, `sm_vld` 0, `stu_sm_ready` 0, `stu_sm_cnt` 0, buffer/sum/`fill`/`wr_ptr` 0. Reset mid-stream discards all history. The first output after reset needs L fresh samples.

## Timing
- Stage 1, the edge after `adc_vld`=1 in cycle n:
  - buffer write, sum/`fill`/`wr_ptr` update;
  - internal `s1_vld` set if the updated `fill` == L.
- Stage 2, the following edge: `sm_data` and `sm_vld` registered. `sm_vld` is high in cycle n+2 for exactly one cycle; `stu_sm_cnt` increments on the same edge.
- Latency is 2 cycles. Throughput is 1 sample/cycle, with no stall and no backpressure.
- `sm_data` holds its value between strobes.
- Flush has priority over a simultaneous sample. A sample already in stage 1 at the time of the flush is still emitted.
- The read of the oldest entry uses pre-write buffer contents. For L = 16 the oldest address equals `wr_ptr`, so this is read-before-write at the same address.

## Structure
- Shared package holds:
  - `SM_DEPTH`, `SM_LEN_MAX`, sum width 20;
  - the clamp function for ke.
- Sub-module `smooth_ring`:
  - 16 × 16 register array with synchronous clear;
  - write port, plus combinational read port at (`wr_ptr` − L);
  - owns `wr_ptr`.
- `smooth_main` owns sum, `fill`, the flush detect, the output register and the status counter.

## Test plan
- **Fill, L=4** (`cfg_sm_len`=2, `cfg_base`=0). Samples 100, 200, 300, 400, 500 → no `sm_vld` for the first 3 samples. `sm_data` = 250, then 350. `stu_sm_ready` rises after sample 4.
- **Baseline floor, L=1.** `cfg_base`=1000, samples 1500 then 800 → `sm_data` = 500, then 0.
- **Clamp and full scale.** `cfg_sm_len`=7, 16 samples of 16'hFFFF → first `sm_vld` on sample 16, `sm_data` = 16'hFFFF. sum = 20'hFFFF0 with no overflow.
- **Back-to-back wrap, L=16.** Send 40 consecutive samples valued 0..39 → each `sm_vld` exactly 2 cycles after its `adc_vld`. Last output = (24+…+39)/16 = 31. `stu_sm_cnt` = 25.
- **Window change mid-stream.** L=8 running; set `cfg_sm_len`=1 together with `adc_vld` → that sample is dropped and `stu_sm_ready` clears. The next 2 samples (10, 20) produce an output of 15.
- **Reset mid-stream.** Assert `rst_n` low while `sm_vld` is pending → all outputs read 0. After release, no `sm_vld` until L new samples have been accepted.

Source files
------------

// File: rtl/smooth_pkg.sv
// ============================================================================
// Module  : smooth_pkg
// Brief   : Shared sizes and window-exponent clamp for the smoothing path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package smooth_pkg;

    localparam int SM_DEPTH   = 16;
    localparam int SM_LEN_MAX = 4;
    localparam int SM_PTR_W   = 4;
    localparam int SM_SUM_W   = 20;
    localparam int SM_FILL_W  = 5;
    localparam int SM_DATA_W  = 16;

    function automatic logic [2:0] sm_clamp_len(input logic [2:0] len);
        return (len > 3'(SM_LEN_MAX)) ? 3'(SM_LEN_MAX) : len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/smooth_ring.sv
// ============================================================================
// Module  : smooth_ring
// Brief   : Sample history ring with clear, write port and oldest-entry read.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module smooth_ring
    import smooth_pkg::*;
(
    input  logic                 clk_sys,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 wr_en,
    input  logic [SM_DATA_W-1:0] wr_data,
    input  logic [2:0]           len_exp,
    output logic [SM_DATA_W-1:0] rd_data
);

    logic [SM_DATA_W-1:0] mem_q [SM_DEPTH];
    logic [SM_DATA_W-1:0] mem_d [SM_DEPTH];
    logic [SM_PTR_W-1:0]  wr_ptr_q;
    logic [SM_PTR_W-1:0]  wr_ptr_d;
    logic [SM_PTR_W-1:0]  rd_addr;

    // Window of 16 truncates to 0, so the oldest entry is the one about to be overwritten.
    assign rd_addr = wr_ptr_q - SM_PTR_W'(5'd1 << len_exp);
    assign rd_data = mem_q[rd_addr];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        for (int i = 0; i < SM_DEPTH; i++) begin
            mem_d[i] = clr ? '0 : mem_q[i];
        end
        if (clr) begin
            wr_ptr_d = '0;
        end else if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + SM_PTR_W'(1);
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            for (int i = 0; i < SM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            for (int i = 0; i < SM_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/smooth_main.sv
// ============================================================================
// Module  : smooth_main
// Brief   : Power-of-two moving average with baseline floor for hit detection.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module smooth_main
    import smooth_pkg::*;
(
    input  logic                 clk_sys,
    input  logic                 rst_n,
    input  logic [15:0]          adc_data,
    input  logic                 adc_vld,
    input  logic [2:0]           cfg_sm_len,
    input  logic [15:0]          cfg_base,
    output logic [15:0]          sm_data,
    output logic                 sm_vld,
    output logic                 stu_sm_ready,
    output logic [15:0]          stu_sm_cnt
);

    logic [2:0]           ke_q, ke_d;
    logic [SM_SUM_W-1:0]  sum_q, sum_d;
    logic [SM_FILL_W-1:0] fill_q, fill_d;
    logic                 s1_vld_q, s1_vld_d;
    logic [15:0]          sm_data_q, sm_data_d;
    logic                 sm_vld_q, sm_vld_d;
    logic [15:0]          cnt_q, cnt_d;

    logic                 flush;
    logic                 accept;
    logic [SM_FILL_W-1:0] win_len;
    logic [SM_DATA_W-1:0] oldest;
    logic [SM_DATA_W-1:0] avg;

    assign ke_d    = sm_clamp_len(cfg_sm_len);
    assign flush   = (ke_d != ke_q);
    assign accept  = adc_vld & ~flush;
    assign win_len = SM_FILL_W'(1) << ke_q;

    smooth_ring u_ring (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .clr     (flush),
        .wr_en   (accept),
        .wr_data (adc_data),
        .len_exp (ke_q),
        .rd_data (oldest)
    );

    // Stage 1: running sum and fill tracking.
    always_comb begin
        sum_d    = sum_q;
        fill_d   = fill_q;
        s1_vld_d = 1'b0;
        if (flush) begin
            sum_d  = '0;
            fill_d = '0;
        end else if (adc_vld) begin
            sum_d = sum_q + SM_SUM_W'(adc_data) - SM_SUM_W'(oldest);
            if (fill_q < win_len) begin
                fill_d = fill_q + SM_FILL_W'(1);
            end
            s1_vld_d = (fill_d == win_len);
        end
    end

    // Stage 2 reads the pre-flush sum and exponent, so an in-flight sample still emits.
    assign avg = SM_DATA_W'(sum_q >> ke_q);

    always_comb begin
        sm_vld_d  = s1_vld_q;
        sm_data_d = sm_data_q;
        cnt_d     = cnt_q;
        if (s1_vld_q) begin
            sm_data_d = (avg > cfg_base) ? (avg - cfg_base) : '0;
            cnt_d     = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            ke_q      <= '0;
            sum_q     <= '0;
            fill_q    <= '0;
            s1_vld_q  <= 1'b0;
            sm_data_q <= '0;
            sm_vld_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            ke_q      <= ke_d;
            sum_q     <= sum_d;
            fill_q    <= fill_d;
            s1_vld_q  <= s1_vld_d;
            sm_data_q <= sm_data_d;
            sm_vld_q  <= sm_vld_d;
            cnt_q     <= cnt_d;
        end
    end

    assign sm_data      = sm_data_q;
    assign sm_vld       = sm_vld_q;
    assign stu_sm_ready = (fill_q == win_len);
    assign stu_sm_cnt   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_smooth_main.sv
// ============================================================================
// Module  : tb_smooth_main
// Brief   : Directed vector bench for the moving-average front end.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_smooth_main;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic [15:0] adc_data;
    logic        adc_vld;
    logic [2:0]  cfg_sm_len;
    logic [15:0] cfg_base;
    logic [15:0] sm_data;
    logic        sm_vld;
    logic        stu_sm_ready;
    logic [15:0] stu_sm_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  len;
        logic [15:0] base;
        logic        vld;
        logic [15:0] data;
        logic        e_vld;
        logic [15:0] e_data;
        logic        e_ready;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    smooth_main dut (
        .clk_sys      (clk_sys),
        .rst_n        (rst_n),
        .adc_data     (adc_data),
        .adc_vld      (adc_vld),
        .cfg_sm_len   (cfg_sm_len),
        .cfg_base     (cfg_base),
        .sm_data      (sm_data),
        .sm_vld       (sm_vld),
        .stu_sm_ready (stu_sm_ready),
        .stu_sm_cnt   (stu_sm_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic step;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] len, input logic [15:0] base,
                         input logic vld, input logic [15:0] data);
        cfg_sm_len = len;
        cfg_base   = base;
        adc_vld    = vld;
        adc_data   = data;
    endtask

    task automatic add(input logic [2:0] len, input logic [15:0] base,
                       input logic vld, input logic [15:0] data,
                       input logic e_vld, input logic [15:0] e_data,
                       input logic e_ready, input logic [15:0] e_cnt);
        vec_t v;
        v.len = len; v.base = base; v.vld = vld; v.data = data;
        v.e_vld = e_vld; v.e_data = e_data; v.e_ready = e_ready; v.e_cnt = e_cnt;
        tbl.push_back(v);
    endtask

    function automatic int avg16(input int last);
        int s = 0;
        for (int i = last - 15; i <= last; i++) s += i;
        return s / 16;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        drive(3'd0, 16'd0, 1'b0, 16'd0);
        repeat (3) step;
        chk("rst_data",  sm_data, 0);
        chk("rst_vld",   sm_vld, 0);
        chk("rst_ready", stu_sm_ready, 0);
        chk("rst_cnt",   stu_sm_cnt, 0);
        rst_n = 1'b1;
        step;
        step;

        // Fill at L=4, baseline floor at L=1, clamped full scale at L=16.
        add(3'd2, 16'd0, 1'b0, 16'd0,   1'b0, 16'd0,   1'b0, 16'd0);
        add(3'd2, 16'd0, 1'b1, 16'd100, 1'b0, 16'd0,   1'b0, 16'd0);
        add(3'd2, 16'd0, 1'b1, 16'd200, 1'b0, 16'd0,   1'b0, 16'd0);
        add(3'd2, 16'd0, 1'b1, 16'd300, 1'b0, 16'd0,   1'b0, 16'd0);
        add(3'd2, 16'd0, 1'b1, 16'd400, 1'b0, 16'd0,   1'b1, 16'd0);
        add(3'd2, 16'd0, 1'b1, 16'd500, 1'b1, 16'd250, 1'b1, 16'd1);
        add(3'd2, 16'd0, 1'b0, 16'd0,   1'b1, 16'd350, 1'b1, 16'd2);
        add(3'd2, 16'd0, 1'b0, 16'd0,   1'b0, 16'd350, 1'b1, 16'd2);
        add(3'd0, 16'd1000, 1'b0, 16'd0,    1'b0, 16'd350, 1'b0, 16'd2);
        add(3'd0, 16'd1000, 1'b1, 16'd1500, 1'b0, 16'd350, 1'b1, 16'd2);
        add(3'd0, 16'd1000, 1'b1, 16'd800,  1'b1, 16'd500, 1'b1, 16'd3);
        add(3'd0, 16'd1000, 1'b0, 16'd0,    1'b1, 16'd0,   1'b1, 16'd4);
        add(3'd0, 16'd1000, 1'b0, 16'd0,    1'b0, 16'd0,   1'b1, 16'd4);
        add(3'd7, 16'd0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 16'd4);
        for (int k = 1; k <= 16; k++) begin
            add(3'd7, 16'd0, 1'b1, 16'hFFFF, 1'b0, 16'd0, (k == 16), 16'd4);
        end
        add(3'd7, 16'd0, 1'b0, 16'd0, 1'b1, 16'hFFFF, 1'b1, 16'd5);
        add(3'd7, 16'd0, 1'b0, 16'd0, 1'b0, 16'hFFFF, 1'b1, 16'd5);

        foreach (tbl[i]) begin
            drive(tbl[i].len, tbl[i].base, tbl[i].vld, tbl[i].data);
            step;
            chk($sformatf("vec%0d_vld", i),   sm_vld,       tbl[i].e_vld);
            chk($sformatf("vec%0d_data", i),  sm_data,      tbl[i].e_data);
            chk($sformatf("vec%0d_ready", i), stu_sm_ready, tbl[i].e_ready);
            chk($sformatf("vec%0d_cnt", i),   stu_sm_cnt,   tbl[i].e_cnt);
        end

        // Back-to-back stream 0..39 at L=16 from a fresh reset.
        rst_n = 1'b0;
        drive(3'd4, 16'd0, 1'b0, 16'd0);
        step;
        rst_n = 1'b1;
        step;
        step;
        for (int t = 0; t < 42; t++) begin
            logic exp_v;
            drive(3'd4, 16'd0, (t < 40), 16'(t));
            step;
            exp_v = (t >= 16) && (t <= 40);
            chk($sformatf("wrap%0d_vld", t), sm_vld, exp_v);
            if (exp_v) chk($sformatf("wrap%0d_data", t), sm_data, avg16(t - 1));
            chk($sformatf("wrap%0d_ready", t), stu_sm_ready, (t >= 15));
        end
        chk("wrap_last_data", sm_data, 31);
        chk("wrap_cnt", stu_sm_cnt, 25);

        // Window change mid-stream: L=8 then cfg_sm_len=1 together with a sample.
        drive(3'd3, 16'd0, 1'b0, 16'd0);
        step;
        for (int k = 1; k <= 8; k++) begin
            drive(3'd3, 16'd0, 1'b1, 16'(10 * k));
            step;
        end
        chk("wchg_ready_l8", stu_sm_ready, 1);
        chk("wchg_vld_pre",  sm_vld, 0);
        drive(3'd1, 16'd0, 1'b1, 16'd999);
        step;
        chk("wchg_inflight_vld",  sm_vld, 1);
        chk("wchg_inflight_data", sm_data, 45);
        chk("wchg_ready_clear",   stu_sm_ready, 0);
        chk("wchg_cnt26",         stu_sm_cnt, 26);
        drive(3'd1, 16'd0, 1'b1, 16'd10);
        step;
        chk("wchg_s1_vld",   sm_vld, 0);
        chk("wchg_s1_ready", stu_sm_ready, 0);
        drive(3'd1, 16'd0, 1'b1, 16'd20);
        step;
        chk("wchg_s2_vld",   sm_vld, 0);
        chk("wchg_s2_ready", stu_sm_ready, 1);
        drive(3'd1, 16'd0, 1'b0, 16'd0);
        step;
        chk("wchg_out_vld",  sm_vld, 1);
        chk("wchg_out_data", sm_data, 15);
        chk("wchg_cnt27",    stu_sm_cnt, 27);

        // Reset while an output is pending in stage 1.
        drive(3'd1, 16'd0, 1'b1, 16'd5);
        step;
        adc_vld = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("mrst_data",  sm_data, 0);
        chk("mrst_vld",   sm_vld, 0);
        chk("mrst_ready", stu_sm_ready, 0);
        chk("mrst_cnt",   stu_sm_cnt, 0);
        step;
        step;
        chk("mrst_hold_vld", sm_vld, 0);
        rst_n = 1'b1;
        step;
        step;
        drive(3'd1, 16'd0, 1'b1, 16'd7);
        step;
        chk("mrst_a_vld",   sm_vld, 0);
        chk("mrst_a_ready", stu_sm_ready, 0);
        drive(3'd1, 16'd0, 1'b1, 16'd9);
        step;
        chk("mrst_b_vld",   sm_vld, 0);
        chk("mrst_b_ready", stu_sm_ready, 1);
        drive(3'd1, 16'd0, 1'b0, 16'd0);
        step;
        chk("mrst_out_vld",  sm_vld, 1);
        chk("mrst_out_data", sm_data, 8);
        chk("mrst_out_cnt",  stu_sm_cnt, 1);
        step;
        chk("mrst_pulse_end", sm_vld, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
